// File: rtl/mbx_channel_arbiter_if.sv
// Core-side send/release handshake plus the shared mailbox channel register bus.
// Latency: none; this is only a bundle of signals.
// Backpressure: req and rel_valid are held by their source until req_ack / rel_ack pulse.
interface mbx_channel_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int N_CH  = 4,
  parameter int CH_IW = 2
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_ctrl;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ack;
  logic [CH_IW-1:0]    ack_ch;
  logic                rel_valid;
  logic [CH_IW-1:0]    rel_ch;
  logic                rel_ack;
  logic [N_CH-1:0]     ch_busy;
  logic [3*N_CH-1:0]   ch_wen;
  logic [31:0]         ch_wdata;
  logic [N_CH-1:0]     ch_clear_intr;
  logic                busy;

  // Arbiter side.
  modport slave (
    input  req, req_ctrl, req_data, rel_valid, rel_ch, ch_busy,
    output req_ack, ack_ch, rel_ack, ch_wen, ch_wdata, ch_clear_intr, busy
  );

  // Cores plus mailbox register blocks.
  modport master (
    output req, req_ctrl, req_data, rel_valid, rel_ch, ch_busy,
    input  req_ack, ack_ch, rel_ack, ch_wen, ch_wdata, ch_clear_intr, busy
  );
endinterface

// File: rtl/mbx_channel_arbiter.sv
// Round-robin sharing of N_CH mailbox channels among N_REQ senders; sequences CTRL, DATA, STATUS writes and serves releases.
// Latency: request sampled in IDLE -> req_ack 4 cycles later (5-cycle send); release -> rel_ack 2 cycles later.
// Backpressure: requests wait in IDLE while every channel is busy; release wins over send. Optional MBX_ARB_CLRINT_EN pulses ch_clear_intr on release.
module mbx_channel_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_CH   = 4,
  parameter int REQ_IW = 2,
  parameter int CH_IW  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  mbx_channel_arbiter_if.slave  mbx
);

  localparam int WEN_W  = 3 * N_CH;
  localparam int F_CTRL = 0;
  localparam int F_DATA = 1;
  localparam int F_STAT = 2;
  localparam logic [WEN_W-1:0] WEN_ONE = WEN_W'(1);
  localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);
  localparam logic [31:0]      STS_SET = 32'h0000_0003;  // INT=1, STS=1

  typedef enum logic [2:0] {
    IDLE, WR_CTRL, WR_DATA, WR_STAT, ACK, REL, REL_ACK
  } state_t;

  state_t              state_q;
  logic [REQ_IW-1:0]   rr_ptr_q;
  logic [REQ_IW-1:0]   grant_q;
  logic [CH_IW-1:0]    ch_q;
  logic [31:0]         data_q;

  logic [N_REQ-1:0]    req_ack_q;
  logic [CH_IW-1:0]    ack_ch_q;
  logic                rel_ack_q;
  logic [WEN_W-1:0]    ch_wen_q;
  logic [31:0]         ch_wdata_q;
  logic                busy_q;

  logic                gnt_vld_d;
  logic [REQ_IW-1:0]   gnt_d;
  logic                free_vld_d;
  logic [CH_IW-1:0]    free_d;
  logic [REQ_IW-1:0]   rr_next_d;
  logic                rel_ok_d;

  function automatic int rr_idx(input logic [REQ_IW-1:0] base, input int off);
    return (int'(base) + off) % N_REQ;
  endfunction

  function automatic logic [WEN_W-1:0] wen_bit(input int ch, input int fld);
    return WEN_ONE << (3 * ch + fld);
  endfunction

  // Requester search wraps from rr_ptr_q; channel search takes the lowest free index.
  always_comb begin
    gnt_vld_d  = 1'b0;
    gnt_d      = '0;
    free_vld_d = 1'b0;
    free_d     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (mbx.req[rr_idx(rr_ptr_q, i)]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = REQ_IW'(rr_idx(rr_ptr_q, i));
      end
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (!mbx.ch_busy[c]) begin
        free_vld_d = 1'b1;
        free_d     = CH_IW'(c);
      end
    end
  end

  assign rr_next_d = REQ_IW'((int'(grant_q) + 1) % N_REQ);
  // Out-of-range release still completes its handshake but touches no channel.
  assign rel_ok_d  = (int'(mbx.rel_ch) < N_CH);

`ifdef MBX_ARB_CLRINT_EN
  logic [N_CH-1:0] clr_q;
  assign mbx.ch_clear_intr = clr_q;
`else
  assign mbx.ch_clear_intr = '0;
`endif

  // Sequencer: outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      req_ack_q  <= '0;
      ack_ch_q   <= '0;
      rel_ack_q  <= 1'b0;
      ch_wen_q   <= '0;
      ch_wdata_q <= '0;
      busy_q     <= 1'b0;
`ifdef MBX_ARB_CLRINT_EN
      clr_q      <= '0;
`endif
    end else begin
      req_ack_q  <= '0;
      ack_ch_q   <= '0;
      rel_ack_q  <= 1'b0;
      ch_wen_q   <= '0;
      ch_wdata_q <= '0;
`ifdef MBX_ARB_CLRINT_EN
      clr_q      <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (mbx.rel_valid) begin
            state_q <= REL;
            busy_q  <= 1'b1;
            if (rel_ok_d) begin
              ch_wen_q <= wen_bit(int'(mbx.rel_ch), F_STAT);
`ifdef MBX_ARB_CLRINT_EN
              clr_q    <= N_CH'(1) << mbx.rel_ch;
`endif
            end
          end else if (gnt_vld_d && free_vld_d) begin
            state_q    <= WR_CTRL;
            busy_q     <= 1'b1;
            grant_q    <= gnt_d;
            ch_q       <= free_d;
            data_q     <= mbx.req_data[32*int'(gnt_d) +: 32];
            ch_wen_q   <= wen_bit(int'(free_d), F_CTRL);
            ch_wdata_q <= mbx.req_ctrl[32*int'(gnt_d) +: 32];
          end
        end
        WR_CTRL: begin
          state_q    <= WR_DATA;
          ch_wen_q   <= wen_bit(int'(ch_q), F_DATA);
          ch_wdata_q <= data_q;
        end
        WR_DATA: begin
          state_q    <= WR_STAT;
          ch_wen_q   <= wen_bit(int'(ch_q), F_STAT);
          ch_wdata_q <= STS_SET;
        end
        WR_STAT: begin
          state_q   <= ACK;
          req_ack_q <= REQ_ONE << grant_q;
          ack_ch_q  <= ch_q;
        end
        ACK: begin
          state_q  <= IDLE;
          rr_ptr_q <= rr_next_d;
          busy_q   <= 1'b0;
        end
        REL: begin
          state_q   <= REL_ACK;
          rel_ack_q <= 1'b1;
        end
        REL_ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mbx.req_ack  = req_ack_q;
  assign mbx.ack_ch   = ack_ch_q;
  assign mbx.rel_ack  = rel_ack_q;
  assign mbx.ch_wen   = ch_wen_q;
  assign mbx.ch_wdata = ch_wdata_q;
  assign mbx.busy     = busy_q;

endmodule

// File: tb/tb_mbx_channel_arbiter.sv
// Bench for mbx_channel_arbiter: directed scenarios then random traffic, scoreboarded against a transaction-level model.
// The model predicts each bus event with its cycle; the monitor pops on every visible output.
// Mailbox status registers are emulated here and feed ch_busy back to the arbiter.
module tb_mbx_channel_arbiter;
  localparam int N_REQ  = 4;
  localparam int N_CH   = 4;
  localparam int REQ_IW = 2;
  localparam int CH_IW  = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mbx_channel_arbiter_if #(.N_REQ(N_REQ), .N_CH(N_CH), .CH_IW(CH_IW)) bus ();

  mbx_channel_arbiter #(.N_REQ(N_REQ), .N_CH(N_CH), .REQ_IW(REQ_IW), .CH_IW(CH_IW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mbx  (bus)
  );

  typedef struct {
    int                cyc;
    logic [3*N_CH-1:0] wen;
    logic [31:0]       wdata;
    logic [N_REQ-1:0]  ack;
    logic [CH_IW-1:0]  ach;
    logic              rack;
    logic [N_CH-1:0]   clr;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  exp_busy [4];

  // Reference model state: next requester to favour, last decision cycle, first cycle idle again.
  int rr      = 0;
  int dec_cyc = -100;
  int idle_at = 0;

  // Emulated channel status registers.
  logic [N_CH-1:0]   mbx_sts    = '0;
  logic [3*N_CH-1:0] pend_wen   = '0;
  logic [31:0]       pend_wdata = '0;
  assign bus.ch_busy = mbx_sts;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3*N_CH-1:0] wen_of(input int ch, input int fld);
    logic [3*N_CH-1:0] w;
    w = '0;
    w[3*ch+fld] = 1'b1;
    return w;
  endfunction

  function automatic logic [N_CH-1:0] clr_exp(input int ch);
    logic [N_CH-1:0] m;
    m = '0;
`ifdef MBX_ARB_CLRINT_EN
    m[ch] = 1'b1;
`endif
    return m;
  endfunction

  function automatic void push_ev(input int c, input logic [3*N_CH-1:0] wen, input logic [31:0] wd,
                                  input logic [N_REQ-1:0] ack, input logic [CH_IW-1:0] ach,
                                  input logic rack, input logic [N_CH-1:0] clr);
    ev_t e;
    e.cyc = c; e.wen = wen; e.wdata = wd; e.ack = ack; e.ach = ach; e.rack = rack; e.clr = clr;
    exp_q.push_back(e);
  endfunction

  // Decide what the arbiter does with the inputs it will sample at the coming edge.
  task automatic model_step();
    int now;
    int g;
    int c;
    int rc;
    bit nb;
    logic [N_REQ-1:0] a;
    ev_t keep[$];
    now = cyc;
    nb  = 1'b0;
    if (!rstn) begin
      keep = {};
      foreach (exp_q[i]) if (exp_q[i].cyc <= now) keep.push_back(exp_q[i]);
      exp_q   = keep;
      rr      = 0;
      dec_cyc = -100;
      idle_at = 0;
    end else if (now >= idle_at) begin
      if (bus.rel_valid) begin
        rc = int'(bus.rel_ch);
        if (rc < N_CH) push_ev(now + 1, wen_of(rc, 2), 32'h0, '0, '0, 1'b0, clr_exp(rc));
        push_ev(now + 2, '0, 32'h0, '0, '0, 1'b1, '0);
        dec_cyc = now;
        idle_at = now + 3;
        nb      = 1'b1;
      end else begin
        g = -1;
        c = -1;
        for (int i = 0; i < N_REQ && g < 0; i++) if (bus.req[(rr + i) % N_REQ]) g = (rr + i) % N_REQ;
        for (int k = 0; k < N_CH && c < 0; k++) if (!bus.ch_busy[k]) c = k;
        if (g >= 0 && c >= 0) begin
          a = '0;
          a[g] = 1'b1;
          push_ev(now + 1, wen_of(c, 0), bus.req_ctrl[32*g +: 32], '0, '0, 1'b0, '0);
          push_ev(now + 2, wen_of(c, 1), bus.req_data[32*g +: 32], '0, '0, 1'b0, '0);
          push_ev(now + 3, wen_of(c, 2), 32'h0000_0003, '0, '0, 1'b0, '0);
          push_ev(now + 4, '0, 32'h0, a, CH_IW'(c), 1'b0, '0);
          rr      = (g + 1) % N_REQ;
          dec_cyc = now;
          idle_at = now + 5;
          nb      = 1'b1;
        end
      end
    end else begin
      nb = (now + 1 < idle_at);
    end
    exp_busy[(now + 1) % 4] = nb;
  endtask

  // Start of a cycle: mailbox registers take last cycle's STATUS write; sources drop acked handshakes.
  task automatic cyc_start();
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) if (pend_wen[3*c+2]) mbx_sts[c] = pend_wdata[0];
    pend_wen   = bus.ch_wen;
    pend_wdata = bus.ch_wdata;
    for (int i = 0; i < N_REQ; i++) if (bus.req_ack[i]) bus.req[i] = 1'b0;
    if (bus.rel_ack) bus.rel_valid = 1'b0;
  endtask

  task automatic cyc_end();
    model_step();
    mon_en = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_start();
      cyc_end();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (cyc + 1 >= idle_at && bus.req == '0 && !bus.rel_valid) break;
      cyc_start();
      cyc_end();
    end
  endtask

  task automatic raise_req(input int i);
    bus.req_ctrl[32*i +: 32] = $urandom();
    bus.req_data[32*i +: 32] = $urandom();
    bus.req[i] = 1'b1;
  endtask

  // Monitor: busy every cycle, and one scoreboard pop per visible bus event.
  initial begin
    ev_t e;
    bit  pres;
    bit  ok;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        pres = (|bus.ch_wen) || (|bus.req_ack) || bus.rel_ack;
        n_chk++;
        if (bus.busy !== exp_busy[cyc % 4] || (!pres && bus.ch_clear_intr !== '0)) begin
          n_fail++;
          $display("FAIL busy@%0d: got busy=%b clr=%h, required busy=%b clr=%h", cyc, bus.busy,
                   bus.ch_clear_intr, exp_busy[cyc % 4], pres ? bus.ch_clear_intr : '0);
        end
        if (pres) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected@%0d: got wen=%h wdata=%h ack=%h rack=%b, required no event", cyc,
                     bus.ch_wen, bus.ch_wdata, bus.req_ack, bus.rel_ack);
          end else begin
            e  = exp_q.pop_front();
            ok = (e.cyc == cyc) && (bus.ch_wen === e.wen) && (bus.req_ack === e.ack) &&
                 (bus.rel_ack === e.rack) && (bus.ch_clear_intr === e.clr) &&
                 (e.wen == '0 || bus.ch_wdata === e.wdata) && (e.ack == '0 || bus.ack_ch === e.ach);
            if (!ok) begin
              n_fail++;
              $display("FAIL event: got cyc=%0d wen=%h wdata=%h ack=%h ach=%0d rack=%b clr=%h, required cyc=%0d wen=%h wdata=%h ack=%h ach=%0d rack=%b clr=%h",
                       cyc, bus.ch_wen, bus.ch_wdata, bus.req_ack, bus.ack_ch, bus.rel_ack, bus.ch_clear_intr,
                       e.cyc, e.wen, e.wdata, e.ack, e.ach, e.rack, e.clr);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          n_chk++;
          n_fail++;
          e = exp_q.pop_front();
          $display("FAIL missing@%0d: got no event, required wen=%h ack=%h rack=%b at cycle %0d", cyc,
                   e.wen, e.ack, e.rack, e.cyc);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int fired;
    bus.req       = '0;
    bus.req_ctrl  = '0;
    bus.req_data  = '0;
    bus.rel_valid = 1'b0;
    bus.rel_ch    = '0;
    rstn          = 1'b0;
    run(3);
    cyc_start(); rstn = 1'b1; cyc_end();

    // Single send on an all-free bank.
    cyc_start();
    bus.req_ctrl[31:0] = 32'hA000_0000;
    bus.req_data[31:0] = 32'h1234_5678;
    bus.req[0] = 1'b1;
    cyc_end();
    run(8);
    cyc_start(); mbx_sts = '0; cyc_end();

    // Fresh reset, then all four requesters at once: grants in order 0..3 on channels 0..3.
    cyc_start(); rstn = 1'b0; cyc_end();
    cyc_start(); rstn = 1'b1; cyc_end();
    cyc_start();
    for (int i = 0; i < N_REQ; i++) raise_req(i);
    cyc_end();
    run(24);

    // All channels busy: request waits until channel 2 is released.
    cyc_start(); mbx_sts = '1; bus.req = '0; raise_req(1); cyc_end();
    run(6);
    cyc_start(); bus.rel_valid = 1'b1; bus.rel_ch = 2'd2; cyc_end();
    run(12);

    // Release and send arrive together: release goes first.
    wait_idle();
    cyc_start();
    mbx_sts = '0;
    bus.rel_valid = 1'b1;
    bus.rel_ch = 2'd1;
    raise_req(0);
    cyc_end();
    run(12);

    // Reset during WR_DATA of a send, then check the pointer restarted at requester 0.
    wait_idle();
    cyc_start(); mbx_sts = '0; raise_req(0); raise_req(2); cyc_end();
    fired = 0;
    for (int i = 0; i < 20; i++) begin
      cyc_start();
      if (fired == 0 && dec_cyc >= 0 && cyc == dec_cyc + 2 && idle_at == dec_cyc + 5) begin
        rstn  = 1'b0;
        fired = 1;
      end else begin
        rstn = 1'b1;
      end
      cyc_end();
    end
    run(16);

    // Requester withdraws during the sequence: ack still comes.
    wait_idle();
    cyc_start(); mbx_sts = '0; raise_req(3); cyc_end();
    cyc_start(); bus.req[3] = 1'b0; cyc_end();
    run(8);

    // Release of channel 3 (interrupt-clear pulse when enabled).
    wait_idle();
    cyc_start(); bus.rel_valid = 1'b1; bus.rel_ch = 2'd3; cyc_end();
    run(5);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      cyc_start();
      for (int i = 0; i < N_REQ; i++) if (!bus.req[i] && $urandom_range(0, 5) == 0) raise_req(i);
      if (!bus.rel_valid && $urandom_range(0, 11) == 0) begin
        bus.rel_valid = 1'b1;
        bus.rel_ch    = CH_IW'($urandom_range(0, N_CH - 1));
      end
      for (int c = 0; c < N_CH; c++) if (mbx_sts[c] && $urandom_range(0, 7) == 0) mbx_sts[c] = 1'b0;
      cyc_end();
    end

    // Drain: receivers free every channel so all pending requests complete.
    for (int n = 0; n < 60; n++) begin
      cyc_start();
      mbx_sts = '0;
      cyc_end();
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d undelivered events, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mbx_channel_arbiter.md
Name: mbx_channel_arbiter

Overview:
Shares a bank of N_CH mailbox channels between N_REQ sender cores. Round-robin arbitration among send requests; the winner is allocated the lowest-index free channel (STS=0). The block then sequences the channel register writes: CTRL, then DATA, then STATUS (INT=1, STS=1). It also serves channel release requests, which write STATUS=0 to free a channel. It sits between the core-side bus and the per-channel mailbox register blocks.

Parameters:
N_REQ, 4, number of sender requesters
N_CH, 4, number of mailbox channels
REQ_IW, 2, requester index width (>= clog2(N_REQ))
CH_IW, 2, channel index width (>= clog2(N_CH))

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req  in  N_REQ  per-requester send request; held high until ack
req_ctrl  in  32*N_REQ  CTRL word per requester; slice i = [32i+31:32i]
req_data  in  32*N_REQ  DATA word per requester
req_ack  out  N_REQ  one-cycle one-hot ack to the granted requester
ack_ch  out  CH_IW  channel index allocated; valid while req_ack!=0
rel_valid  in  1  release request; held until rel_ack
rel_ch  in  CH_IW  channel to release
rel_ack  out  1  one-cycle release acknowledge
ch_busy  in  N_CH  STS bit of each channel's status register
ch_wen  out  3*N_CH  per-channel write enables; bits [3c+2:3c] = {STATUS,DATA,CTRL}
ch_wdata  out  32  write data shared by all channels
ch_clear_intr  out  N_CH  per-channel interrupt clear (optional feature only)
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, synchronous when rstn=0 at a clk edge: FSM=IDLE, rr_ptr=0, all outputs 0, grant/channel registers 0. A reset mid-sequence abandons the sequence with no further writes and no ack.
- All outputs are registered from FSM state and latched grant/channel registers. At most one ch_wen bit is high in any cycle.
- FSM states: IDLE, WR_CTRL, WR_DATA, WR_STAT, ACK, REL, REL_ACK.
- IDLE:
  - If rel_valid=1, latch rel_ch and go to REL. Release has priority over send.
  - Otherwise, if any req is high and any ch_busy bit is 0: pick requester g = first set req bit searching from rr_ptr upward with wrap; pick channel c = lowest index with ch_busy[c]=0. Latch g, c, req_ctrl[g], req_data[g]. Go to WR_CTRL.
  - Otherwise stay in IDLE. Requests wait with no timeout when all channels are busy.
- WR_CTRL: ch_wen[3c]=1, ch_wdata=latched ctrl. Go to WR_DATA.
- WR_DATA: ch_wen[3c+1]=1, ch_wdata=latched data. Go to WR_STAT.
- WR_STAT: ch_wen[3c+2]=1, ch_wdata=32'h0000_0003 (INT=1, STS=1). Go to ACK.
- ACK: req_ack[g]=1, ack_ch=c. rr_ptr <= (g+1) mod N_REQ. Go to IDLE.
- REL: ch_wen[3*rel_ch+2]=1, ch_wdata=0. Go to REL_ACK. A release of an already-free channel still performs the write.
- REL_ACK: rel_ack=1. Go to IDLE.
- Latency: request sampled in IDLE to req_ack = 4 cycles; a send occupies 5 cycles including IDLE. The channel's STS is set by the WR_STAT edge, so the next IDLE evaluation already sees it busy; no double allocation.
- rel_ch >= N_CH: no write is issued, and rel_ack is still given.
- Requester deasserting req before ack: the sequence completes using latched data, and the ack is still pulsed.
- busy=1 in every state except IDLE.

Optional Feature:
MBX_ARB_CLRINT_EN:
- Defined: in the REL state, ch_clear_intr[rel_ch] also pulses for one cycle alongside the STATUS write.
- Undefined: ch_clear_intr is tied to 0, and channel interrupts are cleared only by the STATUS write.

Test Plan:
- Single send: req=4'b0001, ctrl=32'hA000_0000, data=32'h1234_5678, ch_busy=0 -> ch_wen=3'b001@ch0 with wdata A000_0000, then 3'b010 with 1234_5678, then 3'b100 with 0000_0003; req_ack=0001, ack_ch=0 four cycles after IDLE sample.
- Round robin: req=4'b1111 held and all channels free, with the bench setting ch_busy per write -> ack order req0, req1, req2, req3 on channels 0, 1, 2, 3.
- All busy: ch_busy=4'hF, req=0010 -> stays IDLE with no ch_wen. Release ch2 -> REL write wdata=0 on ch_wen[8]. Once ch_busy[2]=0, req1 is granted ch2.
- Release priority: rel_valid=1 (ch1) and req=0001 in the same IDLE cycle -> REL executes first, rel_ack, then the send sequence starts.
- Reset mid-sequence: rstn=0 during WR_DATA -> all outputs 0 next cycle, no STATUS write, no ack, rr_ptr=0.
- With MBX_ARB_CLRINT_EN defined: release ch3 -> ch_clear_intr=4'b1000 for exactly the REL cycle. Undefined: stays 0.
